axi_rdata_unpacker: RTL

Read-path counterpart of the AXI write data packer. It takes one burst descriptor at a time from the read burst FIFO and accepts AXI R-channel beats for that burst. For each beat it extracts only the byte lanes that are valid for the burst address and size, LSByte-justifies them, and pushes one 36-bit {data, byte_en} packet per beat into the read data FIFO toward the peripheral.

---
 rtl/axi_rdata_unpacker.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/axi_rdata_unpacker.sv
// AXI R-channel unpacker: takes one burst descriptor at a time and turns each
// accepted beat into an LSByte-justified {data, byte_en} packet for the read FIFO.
module axi_rdata_unpacker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        b_empty,
    input  logic [31:0] burst_addr,
    input  logic [11:0] burst_info,
    output logic        b_fifo_pop,
    input  logic        axi_rvalid,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rlast,
    output logic        axi_rready,
    input  logic        rdata_full,
    output logic        rdata_fifo_push,
    output logic [35:0] rdata_pckt,
    output logic        resp_err,
    output logic        last_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BEAT = 1'b1
    } state_t;

    state_t      state_r;
    logic [7:0]  len_r;
    logic [1:0]  lane_mask_r;
    logic [1:0]  ptr_r;
    logic [8:0]  beat_cnt_r;
    logic        out_vld_r;
    logic [35:0] out_pckt_r;
    logic        resp_err_r;
    logic        last_err_r;

    logic [1:0]  lo_s;
    logic [1:0]  hi_s;
    logic [2:0]  cnt_s;
    logic [3:0]  be_s;
    logic [31:0] shifted_s;
    logic [31:0] data_s;
    logic        accept_s;
    logic        last_beat_s;
    logic        push_s;
    logic        unused_s;

    // Lane mask is n-1 for n = 1 << size; sizes above a word saturate to a word.
    function automatic logic [1:0] size_to_mask(input logic [3:0] size);
        logic [1:0] mask;
        case (size)
            4'd0:    mask = 2'b00;
            4'd1:    mask = 2'b01;
            default: mask = 2'b11;
        endcase
        return mask;
    endfunction

    function automatic logic [3:0] count_to_be(input logic [2:0] cnt);
        logic [3:0] be;
        case (cnt)
            3'd1:    be = 4'b0001;
            3'd2:    be = 4'b0011;
            3'd3:    be = 4'b0111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] keep_bytes(input logic [31:0] data, input logic [3:0] be);
        return {be[3] ? data[31:24] : 8'h00,
                be[2] ? data[23:16] : 8'h00,
                be[1] ? data[15:8]  : 8'h00,
                be[0] ? data[7:0]   : 8'h00};
    endfunction

    // Only the low address bits select lanes within the 32-bit data path.
    assign unused_s = ^burst_addr[31:2];

    // Per-beat lane window and justified data.
    always_comb begin
        lo_s        = ptr_r & ~lane_mask_r;
        hi_s        = lo_s | lane_mask_r;
        cnt_s       = {1'b0, hi_s} - {1'b0, ptr_r} + 3'd1;
        be_s        = count_to_be(cnt_s);
        shifted_s   = axi_rdata >> {ptr_r, 3'b000};
        data_s      = keep_bytes(shifted_s, be_s);
        last_beat_s = (beat_cnt_r == {1'b0, len_r});
        accept_s    = axi_rvalid & axi_rready;
        push_s      = out_vld_r & ~rdata_full;
    end

    assign axi_rready      = (state_r == ST_BEAT) & (~out_vld_r | ~rdata_full);
    assign b_fifo_pop      = (state_r == ST_IDLE) & ~b_empty & rst_n;
    assign rdata_fifo_push = push_s;
    assign rdata_pckt      = out_pckt_r;
    assign resp_err        = resp_err_r;
    assign last_err        = last_err_r;

    // Burst sequencing: descriptor fetch, lane pointer and beat counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            len_r       <= 8'd0;
            lane_mask_r <= 2'b00;
            ptr_r       <= 2'b00;
            beat_cnt_r  <= 9'd0;
            resp_err_r  <= 1'b0;
            last_err_r  <= 1'b0;
        end else begin
            resp_err_r <= 1'b0;
            last_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!b_empty) begin
                        len_r       <= burst_info[11:4];
                        lane_mask_r <= size_to_mask(burst_info[3:0]);
                        ptr_r       <= burst_addr[1:0];
                        beat_cnt_r  <= 9'd0;
                        state_r     <= ST_BEAT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BEAT: begin
                    if (accept_s) begin
                        ptr_r      <= hi_s + 2'd1;
                        beat_cnt_r <= beat_cnt_r + 9'd1;
                        resp_err_r <= (axi_rresp != 2'b00);
                        last_err_r <= axi_rlast ^ last_beat_s;
                        // The beat count alone ends the burst; rlast is only checked.
                        state_r    <= last_beat_s ? ST_IDLE : ST_BEAT;
                    end else begin
                        state_r <= ST_BEAT;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // One-entry output register; reload on accept, drain on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_r  <= 1'b0;
            out_pckt_r <= 36'd0;
        end else if (accept_s) begin
            out_vld_r  <= 1'b1;
            out_pckt_r <= {data_s, be_s};
        end else if (push_s) begin
            out_vld_r <= 1'b0;
        end else begin
            out_vld_r <= out_vld_r;
        end
    end

endmodule
